nes_rst_clken_gen: RTL and testbench
====================================

// Module: nes_rst_clken_gen
// PURPOSE
//  Parametrised reset sequencer and clock-enable generator for the single-clock NES core.
//  Synchronises the PLL lock flag and holds the core reset for a programmable time after lock.
//  Once released, emits NUM_CH independent fractional-rate clock-enable pulses (CPU, PPU, APU,
//  video) from phase accumulators; replaces ad-hoc per-domain clocks and the OR-ed raw reset.
// PARAMETERS
//  NUM_CH      3     number of clock-enable channels (1..8)
//  ACC_W       16    phase accumulator width; pulse rate = inc / 2^ACC_W per clk
//  RST_HOLD    1023  clk cycles core reset stays asserted after lock is seen stable (>=1)
//  SYNC_STAGES 2     flip-flop stages synchronising pll_locked_in (>=2)
// PORTS
//  clk           in   1             system clock; all logic on rising edge
//  rst           in   1             synchronous, active-high reset
//  pll_locked_in in   1             PLL lock flag, asynchronous to clk
//  inc           in   NUM_CH*ACC_W  per-channel phase increment, channel i at [i*ACC_W +: ACC_W]
//  ch_en         in   NUM_CH        per-channel enable
//  core_rst      out  1             active-high reset to the rest of the core
//  ce            out  NUM_CH        one-cycle clock-enable pulses
//  ready         out  1             high while the sequencer is in RUN
// BEHAVIOUR
//  - Reset: state=WAIT_LOCK, sync chain=0, hold counter=0, all accumulators=0;
//    core_rst=1, ce=0, ready=0. rst asserted at any point returns to this same reset state on
//    the next edge.
//  - lock_s = last stage of the SYNC_STAGES chain on pll_locked_in.
//  - FSM:
//    - WAIT_LOCK: core_rst=1. On lock_s=1 go to HOLD with counter=0.
//    - HOLD: counter increments each cycle. lock_s=0 returns to WAIT_LOCK (counter cleared).
//      When counter==RST_HOLD-1, go to RUN.
//    - RUN: core_rst=0, ready=1, both registered and taking effect on the first RUN cycle.
//      lock_s=0 goes to WAIT_LOCK: core_rst=1 and ce=0 from the next cycle.
//  - Latency: core_rst deasserts exactly SYNC_STAGES+RST_HOLD+1 cycles after pll_locked_in
//    rises, given stable lock and rst already low.
//  - All accumulators are forced to 0 in every non-RUN cycle, so all channels are
//    phase-aligned on entry to RUN.
//  - Per channel in RUN with ch_en[i]=1:
//    - {carry, acc} <= acc + inc_i, computed at ACC_W+1 bits; the sum wraps modulo 2^ACC_W.
//    - ce[i] <= carry: a registered pulse one cycle after the overflowing add.
//    - With inc_i = 2^ACC_W/N, the first pulse is in RUN cycle N (cycle 0 = first RUN cycle),
//      then every N cycles.
//  - ch_en[i]=0: acc_i held at 0 and ce[i]=0 next cycle. Re-enable restarts from acc=0.
//  - inc_i=0 gives no pulses. inc_i=2^ACC_W-1 gives 2^ACC_W-1 pulses per 2^ACC_W cycles,
//    so ce can never be high continuously.
//  - An inc change is used by the add in the cycle it is presented. acc is not cleared.
//  - ce is always 0 while core_rst=1.
// STRUCTURE
//  - Shared include nes_clk_pkg.vh: FSM state localparams (WAIT_LOCK=2'd0, HOLD=2'd1,
//    RUN=2'd2) and a clog2 function used to size the hold counter.
//  - Sub-module nes_phase_acc (ACC_W): one accumulator channel with inputs clear, en, inc and
//    output ce. Instantiated NUM_CH times in a generate loop.
//  - The top holds the synchroniser, hold counter and FSM.
// TESTING
//  - Bench parameters: NUM_CH=3, ACC_W=16, RST_HOLD=8.
//  1. rst=1, then 0, with lock=0 for 50 cycles -> core_rst=1, ce=0, ready=0 throughout.
//  2. Raise lock -> core_rst falls exactly 11 cycles later. ready rises in the same cycle.
//  3. inc = {0x1555, 0x4000, 0x8000}, all ch_en=1 ->
//     - ch0 pulses at RUN cycles 2, 4, 6, ...
//     - ch1 pulses at RUN cycles 4, 8, ...
//     - ch2 averages 1 pulse per 12.0 cycles over 1200 cycles.
//  4. Drop lock for 1 cycle during HOLD -> returns to WAIT_LOCK. Release is re-timed from the
//     next lock rise.
//  5. Drop lock in RUN -> next cycle core_rst=1, ce=000. Relock -> all channels restart
//     phase-aligned (ch1 first pulse at RUN cycle 4).
//  6. ch_en[1]=0 for 7 cycles mid-run, then 1 -> ce[1] silent during that window; next pulse
//     4 cycles after re-enable. ch0 and ch2 unaffected.

Source files
------------

// File: rtl/nes_clk_pkg.sv
// Shared types and helpers for the NES reset sequencer and clock-enable generator.
package nes_clk_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } nes_state_e;

    // Ceiling log2, used to size the hold counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned v = value - 1; v != 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nes_phase_acc.sv
// One fractional-rate clock-enable channel: phase accumulator whose carry becomes the pulse.
module nes_phase_acc #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum_c;

    assign sum_c = {1'b0, acc_q} + {1'b0, inc};

    // Carry of this cycle's add is registered straight into ce.
    always_ff @(posedge clk) begin
        if (clear || !en) begin
            acc_q <= '0;
            ce    <= 1'b0;
        end else begin
            acc_q <= sum_c[ACC_W-1:0];
            ce    <= sum_c[ACC_W];
        end
    end

endmodule

// File: rtl/nes_rst_clken_gen.sv
// Reset sequencer (lock sync, post-lock hold) and NUM_CH phase-accumulator clock enables.
module nes_rst_clken_gen
    import nes_clk_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned RST_HOLD    = 1023,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pll_locked_in,
    input  logic [NUM_CH*ACC_W-1:0] inc,
    input  logic [NUM_CH-1:0]       ch_en,
    output logic                    core_rst,
    output logic [NUM_CH-1:0]       ce,
    output logic                    ready
);

    localparam int unsigned CNT_W = clog2((RST_HOLD < 2) ? 2 : RST_HOLD);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    nes_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   advance_c;
    logic                   acc_clear_c;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, counter, synchroniser and registered reset/ready outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            core_rst <= 1'b1;
            ready    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_locked_in};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            core_rst <= (state_d != RUN);
            ready    <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        advance_c = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else begin
                    advance_c = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Accumulators only advance on RUN cycles that stay in RUN, so ce dies with core_rst.
    assign acc_clear_c = rst || !advance_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        nes_phase_acc #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clk  (clk),
            .clear(acc_clear_c),
            .en   (ch_en[i]),
            .inc  (inc[i*ACC_W +: ACC_W]),
            .ce   (ce[i])
        );
    end

endmodule

// File: tb/tb_nes_rst_clken_gen.sv
// Scoreboard bench for nes_rst_clken_gen: release timing, lock loss, rate and alignment of ce.
module tb_nes_rst_clken_gen;

    localparam int unsigned NUM_CH      = 3;
    localparam int unsigned ACC_W       = 16;
    localparam int unsigned RST_HOLD    = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pll_locked_in;
    logic [NUM_CH*ACC_W-1:0] inc;
    logic [NUM_CH-1:0]       ch_en;
    logic                    core_rst;
    logic [NUM_CH-1:0]       ce;
    logic                    ready;

    int unsigned checks     = 0;
    int unsigned failures   = 0;
    int unsigned ch2_pulses = 0;
    int unsigned ph [NUM_CH];
    logic [4:0]  sb_q [$];

    always #5 clk = ~clk;

    nes_rst_clken_gen #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .RST_HOLD   (RST_HOLD),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked_in(pll_locked_in),
        .inc          (inc),
        .ch_en        (ch_en),
        .core_rst     (core_rst),
        .ce           (ce),
        .ready        (ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // True when an accumulator started at 0 wraps on its n-th add (pulse seen in phase n).
    function automatic logic pulse_at(input logic [15:0] step_inc, input int unsigned n);
        longint unsigned a, b;
        if (n == 0) return 1'b0;
        a = n;
        a = (a * step_inc) >> 16;
        b = n - 1;
        b = (b * step_inc) >> 16;
        return a != b;
    endfunction

    // Expected {core_rst, ready, ce} queued before the edge, compared after it.
    task automatic step(input string tag, input logic [4:0] exp);
        logic [4:0] e;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (ce[2] === 1'b1) ch2_pulses++;
        check(tag, 32'({core_rst, ready, ce}), 32'(e));
    endtask

    task automatic cycle_rst(input string tag, input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            for (int i = 0; i < int'(NUM_CH); i++) ph[i] = 0;
            step(tag, 5'b10000);
        end
    endtask

    task automatic cycle_run(input string tag, input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            logic [2:0] e;
            e = '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                ph[i] = ch_en[i] ? ph[i] + 1 : 0;
                e[i]  = ch_en[i] && pulse_at(inc[i*ACC_W +: ACC_W], ph[i]);
            end
            step(tag, {2'b01, e});
        end
    endtask

    // Lock (or reset release) presented this cycle: RUN starts exactly 11 samples later.
    task automatic release_seq(input string tag);
        cycle_rst(tag, SYNC_STAGES + RST_HOLD);
        for (int i = 0; i < int'(NUM_CH); i++) ph[i] = 0;
        step({tag, "_rel"}, 5'b01000);
    endtask

    initial begin
        rst           = 1'b1;
        pll_locked_in = 1'b0;
        inc           = {16'h1555, 16'h4000, 16'h8000};
        ch_en         = 3'b111;
        for (int i = 0; i < int'(NUM_CH); i++) ph[i] = 0;

        cycle_rst("reset", 3);
        rst = 1'b0;
        cycle_rst("no_lock", 50);

        pll_locked_in = 1'b1;
        cycle_rst("hold", 5);
        pll_locked_in = 1'b0;
        cycle_rst("hold_drop", 1);
        pll_locked_in = 1'b1;
        release_seq("relock");

        ch2_pulses = 0;
        cycle_run("run", 1200);
        check("ch2_rate", 32'(ch2_pulses >= 99 && ch2_pulses <= 101), 32'd1);

        ch_en = 3'b101;
        cycle_run("ch1_off", 7);
        ch_en = 3'b111;
        cycle_run("ch1_on", 8);

        pll_locked_in = 1'b0;
        cycle_run("lock_drop", SYNC_STAGES);
        cycle_rst("unlocked", 5);
        pll_locked_in = 1'b1;
        release_seq("relock2");
        inc[2*ACC_W +: ACC_W] = 16'h0000;
        cycle_run("realign", 16);

        rst = 1'b1;
        cycle_rst("rst_run", 1);
        rst = 1'b0;
        release_seq("rst_rel");
        inc[2*ACC_W +: ACC_W] = 16'hFFFF;
        cycle_run("inc_max", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
